// File: rtl/snake_score_pkg.sv
// Shared constants and FSM state encoding for the snake score keeper.
package snake_score_pkg;
  localparam int SPEED_W = 28;
  localparam logic [3:0] BCD_NINE = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_t;
endpackage

// File: rtl/bcd_digit_inc.sv
// One BCD digit of a ripple incrementer: 9 -> 0 with carry, otherwise +1 when inc_in.
module bcd_digit_inc
  import snake_score_pkg::*;
(
  input  logic [3:0] digit_in,
  input  logic       inc_in,
  output logic [3:0] digit_out,
  output logic       carry_out,
  output logic       is_nine
);
  assign is_nine   = (digit_in == BCD_NINE);
  assign carry_out = inc_in & is_nine;
  assign digit_out = !inc_in ? digit_in : (is_nine ? 4'd0 : digit_in + 4'd1);
endmodule

// File: rtl/snake_score_keeper.sv
// Saturating BCD score, level/move-speed derivation and session hi-score for the snake game.
// Define SNAKE_HISCORE_EN to build the hi-score register, compare logic and new_record pulse.
module snake_score_keeper
  import snake_score_pkg::*;
#(
  parameter int                 DIGITS     = 2,
  parameter int                 LEVELS     = 3,
  parameter int                 LEVEL_STEP = 10,
  parameter logic [SPEED_W-1:0] BASE_SPEED = 28'd50000000,
  parameter logic [SPEED_W-1:0] SPEED_STEP = 28'd12500000,
  localparam int                LVL_W      = (LEVELS > 1) ? $clog2(LEVELS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  game_over,
  input  logic                  target_ate,
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic [4*DIGITS-1:0]   hi_score_bcd,
  output logic [LVL_W-1:0]      level,
  output logic [SPEED_W-1:0]    mov_speed,
  output logic                  level_up,
  output logic                  saturated,
  output logic                  new_record
);
  localparam int SW    = 4 * DIGITS;
  localparam int CNT_W = (LEVEL_STEP > 1) ? $clog2(LEVEL_STEP) : 1;
  localparam logic [LVL_W-1:0] TOP_LVL   = LVL_W'(LEVELS - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(LEVEL_STEP - 1);

  state_t            state, state_nxt;
  logic              ate_q;
  logic              eat;
  logic [SW-1:0]     score_inc;
  logic [SW-1:0]     score_nxt;
  logic [DIGITS:0]   carry;
  logic [DIGITS-1:0] nine;
  logic [CNT_W-1:0]  step_cnt;

  // An edge seen while paused or outside RUN is dropped, never queued.
  assign eat      = target_ate & ~ate_q & (state == ST_RUN) & ~pause;
  assign carry[0] = eat;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_inc u_digit (
      .digit_in  (score_bcd[4*g +: 4]),
      .inc_in    (carry[g]),
      .digit_out (score_inc[4*g +: 4]),
      .carry_out (carry[g+1]),
      .is_nine   (nine[g])
    );
  end

  // A carry out of the top digit means the score is all-9s: hold instead of wrapping.
  assign score_nxt = carry[DIGITS] ? score_bcd : score_inc;
  assign saturated = &nine;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN: begin
        if (start)          state_nxt = ST_RUN;
        else if (game_over) state_nxt = ST_OVER;
      end
      ST_OVER: if (start) state_nxt = ST_RUN;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ate_q     <= 1'b0;
      score_bcd <= '0;
      step_cnt  <= '0;
      level     <= '0;
      mov_speed <= BASE_SPEED;
      level_up  <= 1'b0;
    end else begin
      state     <= state_nxt;
      ate_q     <= target_ate;
      level_up  <= 1'b0;
      mov_speed <= BASE_SPEED - SPEED_W'(level) * SPEED_STEP;
      if (start) begin
        score_bcd <= '0;
        step_cnt  <= '0;
        level     <= '0;
      end else if (eat) begin
        score_bcd <= score_nxt;
        // The step counter freezes once the top level is reached.
        if (level != TOP_LVL) begin
          if (step_cnt == STEP_LAST) begin
            step_cnt <= '0;
            level    <= level + 1'b1;
            level_up <= 1'b1;
          end else begin
            step_cnt <= step_cnt + 1'b1;
          end
        end
      end
    end
  end

`ifdef SNAKE_HISCORE_EN
  logic          go_accept;
  logic [SW-1:0] final_score;
  logic [SW-1:0] hi_q;
  logic          rec_q;

  // BCD nibbles compare correctly as a plain unsigned number.
  assign go_accept   = (state == ST_RUN) & game_over & ~start;
  assign final_score = eat ? score_nxt : score_bcd;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_q  <= '0;
      rec_q <= 1'b0;
    end else begin
      rec_q <= 1'b0;
      if (go_accept && (final_score > hi_q)) begin
        hi_q  <= final_score;
        rec_q <= 1'b1;
      end
    end
  end

  assign hi_score_bcd = hi_q;
  assign new_record   = rec_q;
`else
  assign hi_score_bcd = '0;
  assign new_record   = 1'b0;
`endif
endmodule

// File: tb/tb_snake_score_keeper.sv
// Bench for snake_score_keeper: directed and random stimulus checked against an eat-count model.
module tb_snake_score_keeper;
  localparam int DIGITS     = 2;
  localparam int LEVELS     = 3;
  localparam int LEVEL_STEP = 10;
  localparam int BASE       = 50000000;
  localparam int SSTEP      = 12500000;
  localparam int MAX_SCORE  = 99;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        pause;
  logic        game_over;
  logic        target_ate;
  logic [7:0]  score_bcd;
  logic [7:0]  hi_score_bcd;
  logic [1:0]  level;
  logic [27:0] mov_speed;
  logic        level_up;
  logic        saturated;
  logic        new_record;

  typedef struct packed {
    logic [7:0]  score;
    logic [7:0]  hi;
    logic [1:0]  level;
    logic [27:0] speed;
    logic        level_up;
    logic        sat;
    logic        rec;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference state: everything is derived from the number of eats since start.
  bit m_run;
  bit m_ate;
  int m_eats;
  int m_lvl;
  int m_speed;
  int m_hi;

  snake_score_keeper #(
    .DIGITS     (DIGITS),
    .LEVELS     (LEVELS),
    .LEVEL_STEP (LEVEL_STEP),
    .BASE_SPEED (28'd50000000),
    .SPEED_STEP (28'd12500000)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .pause        (pause),
    .game_over    (game_over),
    .target_ate   (target_ate),
    .score_bcd    (score_bcd),
    .hi_score_bcd (hi_score_bcd),
    .level        (level),
    .mov_speed    (mov_speed),
    .level_up     (level_up),
    .saturated    (saturated),
    .new_record   (new_record)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int score_of(input int eats);
    return (eats < MAX_SCORE) ? eats : MAX_SCORE;
  endfunction

  task automatic cycle(input bit rn, input bit st, input bit pa, input bit go, input bit ta);
    obs_t e;
    bit   eat;
    bit   lu;
    bit   nr;
    int   new_lvl;
    rst_n      = rn;
    start      = st;
    pause      = pa;
    game_over  = go;
    target_ate = ta;
    lu = 1'b0;
    nr = 1'b0;
    if (!rn) begin
      m_run = 1'b0; m_ate = 1'b0; m_eats = 0; m_lvl = 0; m_speed = BASE; m_hi = 0;
    end else begin
      eat     = ta && !m_ate && m_run && !pa;
      m_speed = BASE - m_lvl * SSTEP;
      if (st) begin
        m_run = 1'b1; m_eats = 0; m_lvl = 0;
      end else begin
        if (eat) begin
          m_eats++;
          new_lvl = m_eats / LEVEL_STEP;
          if (new_lvl > LEVELS - 1) new_lvl = LEVELS - 1;
          lu    = (new_lvl > m_lvl);
          m_lvl = new_lvl;
        end
        if (go && m_run) begin
          m_run = 1'b0;
`ifdef SNAKE_HISCORE_EN
          if (score_of(m_eats) > m_hi) begin
            m_hi = score_of(m_eats);
            nr   = 1'b1;
          end
`endif
        end
      end
      m_ate = ta;
    end
    e.score    = to_bcd(score_of(m_eats));
    e.hi       = to_bcd(m_hi);
    e.level    = 2'(m_lvl);
    e.speed    = 28'(m_speed);
    e.level_up = lu;
    e.sat      = (m_eats >= MAX_SCORE);
    e.rec      = nr;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic eat_edges(input int n, input bit pa);
    for (int i = 0; i < n; i++) begin
      cycle(1'b1, 1'b0, pa, 1'b0, 1'b1);
      cycle(1'b1, 1'b0, pa, 1'b0, 1'b0);
    end
  endtask

  task automatic do_start();
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_over();
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: every negedge presents one registered result for the edge just passed.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t e;
      e = exp_q.pop_front();
      chk("score_bcd",    32'(score_bcd),    32'(e.score));
      chk("hi_score_bcd", 32'(hi_score_bcd), 32'(e.hi));
      chk("level",        32'(level),        32'(e.level));
      chk("mov_speed",    32'(mov_speed),    32'(e.speed));
      chk("level_up",     32'(level_up),     32'(e.level_up));
      chk("saturated",    32'(saturated),    32'(e.sat));
      chk("new_record",   32'(new_record),   32'(e.rec));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not complete in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; pause = 1'b0; game_over = 1'b0; target_ate = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    eat_edges(3, 1'b0);                 // ignored in IDLE
    do_over();                          // ignored in IDLE
    do_start();
    eat_edges(10, 1'b0);                // score 10, level 1
    idle(2);
    do_over();
    eat_edges(3, 1'b0);                 // ignored in OVER
    do_start();
    eat_edges(105, 1'b0);               // saturate at 99, level 2
    do_over();
    do_start();
    eat_edges(4, 1'b1);                 // paused edges lost
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0); // start beats game_over
    eat_edges(2, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_start(); eat_edges(7, 1'b0); do_over();
    do_start(); eat_edges(5, 1'b0); do_over();
    do_start(); eat_edges(6, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1); // eat and game_over together
    idle(2);
    do_start(); eat_edges(23, 1'b0); do_start();
    idle(2);
    do_start(); eat_edges(4, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // reset mid-game
    idle(2);
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 399) != 0,
            $urandom_range(0, 59) == 0,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 39) == 0,
            $urandom_range(0, 1) == 1);
    end
    idle(2);
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d results never observed, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
